// File: rtl/seq_step_fsm_pkg.sv
// Shared types and helpers for the cyclic step sequencer.
package seq_step_pkg;

  // Which registered pulse fires next cycle; one reason per cycle keeps the pulses exclusive.
  typedef enum logic [1:0] {
    P_NONE,
    P_WRAP,
    P_ERR,
    P_TIMEOUT
  } pulse_e;

  // Step counter width: max(1, $clog2(depth)).
  function automatic int step_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Step width of the default 4-step sequencer.
  localparam int DEFAULT_SW = step_w(4);

  // Reset value of expected-symbol entry i: (i+1) mod 2**sym_w.
  function automatic int default_exp(input int i, input int sym_w);
    return (i + 1) % (1 << sym_w);
  endfunction

endpackage

// File: rtl/seq_step_fsm_if.sv
// Symbol/config input and step/status output bundle of the step sequencer.
interface seq_step_fsm_if #(
  parameter int SYM_W = 2,
  parameter int SW    = 2
);
  logic             cfg_we;
  logic [SW-1:0]    cfg_idx;
  logic [SYM_W-1:0] cfg_sym;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic [SW-1:0]    step;
  logic [SYM_W-1:0] out_code;
  logic             wrap_pulse;
  logic             err_pulse;
  logic             timeout_pulse;

  modport master (
    output cfg_we, cfg_idx, cfg_sym, in_valid, in_sym,
    input  step, out_code, wrap_pulse, err_pulse, timeout_pulse
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_sym, in_valid, in_sym,
    output step, out_code, wrap_pulse, err_pulse, timeout_pulse
  );
endinterface

// File: rtl/seq_step_fsm_timer.sv
// Idle counter for a nonzero step; flags expiry after TIMEOUT cycles without a match.
module seq_step_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT - 1));

  // Count idle cycles; restart on clear or once the expiry has been taken.
  always_ff @(posedge clk) begin
    if (reset || clear || expired) cnt <= '0;
    else                           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/seq_step_fsm.sv
// Cyclic step sequencer: advances when the valid symbol matches the step's table entry.
// Optional idle timeout enabled by defining SEQ_STEP_TIMEOUT_EN.
module seq_step_fsm
  import seq_step_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int DEPTH   = 4,
  parameter int STRICT  = 0,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  seq_step_fsm_if.slave bus
);
  localparam int            SW   = step_w(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

  logic [SYM_W-1:0] exp_tbl [DEPTH];
  logic [SYM_W-1:0] cur_exp;
  logic             step_ok;
  logic             hit;
  logic             expired;
  logic [SW-1:0]    step_q, step_d;
  pulse_e           reason;
  logic             wrap_q, err_q, tmo_q;

  // Expected-symbol table; out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset)                                   exp_tbl[i] <= SYM_W'(default_exp(i, SYM_W));
      else if (bus.cfg_we && bus.cfg_idx == SW'(i)) exp_tbl[i] <= bus.cfg_sym;
    end
  end

  // Look up the current step's entry; step_ok is low for unreachable encodings.
  always_comb begin
    cur_exp = '0;
    step_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (step_q == SW'(i)) begin
        cur_exp = exp_tbl[i];
        step_ok = 1'b1;
      end
    end
  end

  assign hit = bus.in_valid && step_ok && (bus.in_sym == cur_exp);

`ifdef SEQ_STEP_TIMEOUT_EN
  logic tmr_clear;
  assign tmr_clear = hit || (step_q == '0);

  seq_step_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Next step and pulse reason; match beats strict mismatch beats timeout.
  always_comb begin
    step_d = step_q;
    reason = P_NONE;
    if (!step_ok) begin
      step_d = '0;
    end else if (hit) begin
      if (step_q == LAST) begin
        step_d = '0;
        reason = P_WRAP;
      end else begin
        step_d = step_q + SW'(1);
      end
    end else if (bus.in_valid && STRICT != 0) begin
      step_d = '0;
      reason = P_ERR;
    end else if (expired) begin
      step_d = '0;
      reason = P_TIMEOUT;
    end
  end

  // Step and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      wrap_q <= (reason == P_WRAP);
      err_q  <= (reason == P_ERR);
      tmo_q  <= (reason == P_TIMEOUT);
    end
  end

  assign bus.step          = step_q;
  assign bus.out_code      = SYM_W'(32'(step_q) + 32'd1);
  assign bus.wrap_pulse    = wrap_q;
  assign bus.err_pulse     = err_q;
  assign bus.timeout_pulse = tmo_q;
endmodule

// File: tb/tb_seq_step_fsm.sv
// Bench for seq_step_fsm: default, strict and DEPTH=5/SYM_W=3 instances, queue scoreboard.
module tb_seq_step_fsm;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  seq_step_fsm_if #(.SYM_W(2), .SW(2)) if0 ();
  seq_step_fsm_if #(.SYM_W(2), .SW(2)) if1 ();
  seq_step_fsm_if #(.SYM_W(3), .SW(3)) if2 ();

  seq_step_fsm #(.SYM_W(2), .DEPTH(4), .STRICT(0), .TIMEOUT(16)) u0 (.clk(clk), .reset(reset), .bus(if0));
  seq_step_fsm #(.SYM_W(2), .DEPTH(4), .STRICT(1), .TIMEOUT(16)) u1 (.clk(clk), .reset(reset), .bus(if1));
  seq_step_fsm #(.SYM_W(3), .DEPTH(5), .STRICT(0), .TIMEOUT(16)) u2 (.clk(clk), .reset(reset), .bus(if2));

  // {step, code, wrap, err, timeout}, each field zero-extended to 4 bits
  logic [10:0] obs0, obs1, obs2;
  assign obs0 = {2'b00, if0.step, 2'b00, if0.out_code, if0.wrap_pulse, if0.err_pulse, if0.timeout_pulse};
  assign obs1 = {2'b00, if1.step, 2'b00, if1.out_code, if1.wrap_pulse, if1.err_pulse, if1.timeout_pulse};
  assign obs2 = {1'b0, if2.step, 1'b0, if2.out_code, if2.wrap_pulse, if2.err_pulse, if2.timeout_pulse};

  function automatic logic [10:0] pk(input int st, input int cd, input bit w, input bit e, input bit t);
    return {4'(st), 4'(cd), w, e, t};
  endfunction

  // s < 0 means in_valid=0 (symbol still driven, to show it is ignored)
  task automatic drv0(input int s, input bit we = 1'b0, input int idx = 0, input int cs = 0);
    if0.in_valid = (s >= 0); if0.in_sym = 2'(s);
    if0.cfg_we = we; if0.cfg_idx = 2'(idx); if0.cfg_sym = 2'(cs);
    @(posedge clk); #1;
  endtask

  task automatic drv1(input int s);
    if1.in_valid = (s >= 0); if1.in_sym = 2'(s);
    @(posedge clk); #1;
  endtask

  task automatic drv2(input int s, input bit we = 1'b0, input int idx = 0, input int cs = 0);
    if2.in_valid = (s >= 0); if2.in_sym = 3'(s);
    if2.cfg_we = we; if2.cfg_idx = 3'(idx); if2.cfg_sym = 3'(cs);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    reset = 1'b1;
    drv0(-1); drv1(-1); drv2(-1);
    exp_q.push_back(pk(0, 1, 0, 0, 0));
    exp_q.push_back(pk(0, 1, 0, 0, 0));
    exp_q.push_back(pk(0, 1, 0, 0, 0));
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_u0: got %h expected %h", obs0, e); end
    e = exp_q.pop_front(); checks++;
    if (obs1 !== e) begin errors++; $display("FAIL reset_u1: got %h expected %h", obs1, e); end
    e = exp_q.pop_front(); checks++;
    if (obs2 !== e) begin errors++; $display("FAIL reset_u2: got %h expected %h", obs2, e); end
    reset = 1'b0;
    exp_q.push_back(pk(0, 1, 0, 0, 0));
    drv0(-1);
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_release: got %h expected %h", obs0, e); end
  endtask

  task automatic test_match_seq();
    int sym[5];
    logic [10:0] ex[5];
    logic [10:0] e;
    sym = '{1, 2, 3, 0, -1};
    ex  = '{pk(1,2,0,0,0), pk(2,3,0,0,0), pk(3,0,0,0,0), pk(0,1,1,0,0), pk(0,1,0,0,0)};
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(ex[k]);
      drv0(sym[k]);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL match_seq[%0d]: got %h expected %h", k, obs0, e); end
    end
  endtask

  task automatic test_hold_mismatch();
    int sym[7];
    logic [10:0] ex[7];
    logic [10:0] e;
    sym = '{-1, 1, 2, 1, -1, 3, 0};
    ex  = '{pk(0,1,0,0,0), pk(1,2,0,0,0), pk(2,3,0,0,0), pk(2,3,0,0,0),
            pk(2,3,0,0,0), pk(3,0,0,0,0), pk(0,1,1,0,0)};
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(ex[k]);
      drv0(sym[k]);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL hold_mismatch[%0d]: got %h expected %h", k, obs0, e); end
    end
  endtask

  task automatic test_strict();
    int sym[8];
    logic [10:0] ex[8];
    logic [10:0] e;
    sym = '{1, 2, 1, -1, 2, 1, -1, 0};
    ex  = '{pk(1,2,0,0,0), pk(2,3,0,0,0), pk(0,1,0,1,0), pk(0,1,0,0,0),
            pk(0,1,0,1,0), pk(1,2,0,0,0), pk(1,2,0,0,0), pk(0,1,0,1,0)};
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(ex[k]);
      drv1(sym[k]);
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL strict[%0d]: got %h expected %h", k, obs1, e); end
    end
  endtask

  // exp[0] <= 3 written in the same cycle as a compare of 1 against the old entry
  task automatic test_table_write();
    int sym[8];
    logic [10:0] ex[8];
    logic [10:0] e;
    sym = '{1, 2, 3, 0, 1, 3, 2, 3};
    ex  = '{pk(1,2,0,0,0), pk(2,3,0,0,0), pk(3,0,0,0,0), pk(0,1,1,0,0),
            pk(0,1,0,0,0), pk(1,2,0,0,0), pk(2,3,0,0,0), pk(3,0,0,0,0)};
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(ex[k]);
      drv0(sym[k], k == 0, 0, 3);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL table_write[%0d]: got %h expected %h", k, obs0, e); end
    end
  endtask

  // Entered at step 3 with exp[0]=3; reset alongside a matching symbol
  task automatic test_reset_mid();
    int sym[4];
    logic [10:0] ex[4];
    logic [10:0] e;
    reset = 1'b1;
    exp_q.push_back(pk(0, 1, 0, 0, 0));
    drv0(0);
    reset = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_mid: got %h expected %h", obs0, e); end
    sym = '{1, 2, 3, 0};
    ex  = '{pk(1,2,0,0,0), pk(2,3,0,0,0), pk(3,0,0,0,0), pk(0,1,1,0,0)};
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ex[k]);
      drv0(sym[k]);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL reset_defaults[%0d]: got %h expected %h", k, obs0, e); end
    end
  endtask

  task automatic test_depth5();
    int sym[7];
    int idx[7];
    logic [10:0] ex[7];
    logic [10:0] e;
    sym = '{-1, -1, 1, 2, 3, 4, 5};
    idx = '{7, 5, 0, 0, 0, 0, 0};
    ex  = '{pk(0,1,0,0,0), pk(0,1,0,0,0), pk(1,2,0,0,0), pk(2,3,0,0,0),
            pk(3,4,0,0,0), pk(4,5,0,0,0), pk(0,1,1,0,0)};
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(ex[k]);
      drv2(sym[k], k < 2, idx[k], 0);
      e = exp_q.pop_front(); checks++;
      if (obs2 !== e) begin errors++; $display("FAIL depth5[%0d]: got %h expected %h", k, obs2, e); end
    end
  endtask

`ifdef SEQ_STEP_TIMEOUT_EN
  task automatic test_timeout();
    logic [10:0] e;
    exp_q.push_back(pk(1, 2, 0, 0, 0));
    drv0(1);
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL tmo_enter: got %h expected %h", obs0, e); end
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back(pk(1, 2, 0, 0, 0));
      drv0(-1);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL tmo_idle[%0d]: got %h expected %h", k, obs0, e); end
    end
    exp_q.push_back(pk(0, 1, 0, 0, 1));
    drv0(-1);
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL tmo_fire: got %h expected %h", obs0, e); end
    exp_q.push_back(pk(0, 1, 0, 0, 0));
    drv0(-1);
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL tmo_once: got %h expected %h", obs0, e); end
    exp_q.push_back(pk(1, 2, 0, 0, 0));
    drv0(1);
    void'(exp_q.pop_front());
    for (int k = 0; k < 15; k++) drv0(-1);
    exp_q.push_back(pk(2, 3, 0, 0, 0));
    drv0(2);
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL tmo_match_wins: got %h expected %h", obs0, e); end
    exp_q.push_back(pk(3, 0, 0, 0, 0));
    drv0(3);
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL tmo_after_match: got %h expected %h", obs0, e); end
    drv0(0);
  endtask
`else
  task automatic test_timeout();
    logic [10:0] e;
    drv0(1);
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(pk(1, 2, 0, 0, 0));
      drv0(-1);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL no_timeout[%0d]: got %h expected %h", k, obs0, e); end
    end
    drv0(2); drv0(3);
    exp_q.push_back(pk(0, 1, 1, 0, 0));
    drv0(0);
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL no_timeout_wrap: got %h expected %h", obs0, e); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    if0.in_valid = 1'b0; if0.in_sym = '0; if0.cfg_we = 1'b0; if0.cfg_idx = '0; if0.cfg_sym = '0;
    if1.in_valid = 1'b0; if1.in_sym = '0; if1.cfg_we = 1'b0; if1.cfg_idx = '0; if1.cfg_sym = '0;
    if2.in_valid = 1'b0; if2.in_sym = '0; if2.cfg_we = 1'b0; if2.cfg_idx = '0; if2.cfg_sym = '0;
    test_reset();
    test_match_seq();
    test_hold_mismatch();
    test_strict();
    test_table_write();
    test_reset_mid();
    test_depth5();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
